// File: rtl/ring_counter_pkg.sv
// Shared types and helpers for the four-stage one-hot LED ring counter.
package ring_counter_pkg;

   localparam int NUM_STAGES = 4;

   typedef logic [NUM_STAGES-1:0] ring_t;

   // One-hot pattern with only bit idx set.
   function automatic ring_t onehot_at(input logic [1:0] idx);
      ring_t r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // True when exactly one bit of the ring is set.
   function automatic logic is_onehot(input ring_t r);
      return (r != '0) && ((r & (r - ring_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/ring_counter_prescaler.sv
// Divides clk by STEP_DIV into a one-cycle step tick; the tick is constant high when STEP_DIV is 1.
module ring_counter_prescaler #(
   parameter int STEP_DIV = 1
) (
   input  logic clk,
   input  logic sw,
   output logic tick
);

   generate
      if (STEP_DIV <= 1) begin : g_bypass
         assign tick = 1'b1;
      end else begin : g_count
         localparam int CNT_W = $clog2(STEP_DIV);
         localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

         logic [CNT_W-1:0] cnt_p0;

         always_ff @(posedge clk or posedge sw) begin
            if (sw) begin
               cnt_p0 <= '0;
            end else if (cnt_p0 == LAST) begin
               cnt_p0 <= '0;
            end else begin
               cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
         end

         assign tick = (cnt_p0 == LAST);
      end
   endgenerate

endmodule

// File: rtl/ring_counter.sv
// Four-stage one-hot LED ring; rotates LED_1->LED_4 on each prescaler tick.
// Define RING_COUNTER_SAFE_EN to reload the reset pattern when the ring is not one-hot.
module ring_counter
   import ring_counter_pkg::*;
#(
   parameter int STEP_DIV  = 1,
   parameter int RESET_POS = 0
) (
   input  logic clk,
   input  logic sw,
   output logic LED_1,
   output logic LED_2,
   output logic LED_3,
   output logic LED_4
);

   localparam ring_t RESET_RING = onehot_at(2'(RESET_POS));

   logic  tick;
   ring_t ring_p0;
   ring_t ring_next;

   ring_counter_prescaler #(
      .STEP_DIV (STEP_DIV)
   ) u_prescaler (
      .clk  (clk),
      .sw   (sw),
      .tick (tick)
   );

   always_comb begin
      ring_next = ring_p0;
      if (tick) begin
`ifdef RING_COUNTER_SAFE_EN
         if (!is_onehot(ring_p0)) begin
            ring_next = RESET_RING;
         end else begin
            ring_next = {ring_p0[NUM_STAGES-2:0], ring_p0[NUM_STAGES-1]};
         end
`else
         ring_next = {ring_p0[NUM_STAGES-2:0], ring_p0[NUM_STAGES-1]};
`endif
      end
   end

   // Stage p0: ring register, LEDs come straight from its flops
   always_ff @(posedge clk or posedge sw) begin
      if (sw) begin
         ring_p0 <= RESET_RING;
      end else begin
         ring_p0 <= ring_next;
      end
   end

   assign LED_1 = ring_p0[0];
   assign LED_2 = ring_p0[1];
   assign LED_3 = ring_p0[2];
   assign LED_4 = ring_p0[3];

endmodule

// File: tb/tb_ring_counter.sv
// Scoreboard bench for ring_counter: default instance and a STEP_DIV=3, RESET_POS=2 instance.
module tb_ring_counter;

   logic clk;
   logic sw;
   logic a1, a2, a3, a4;
   logic b1, b2, b3, b4;

   typedef struct {
      logic [3:0] exp_a;
      logic [3:0] exp_b;
      int         step;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;
   event chk_ev;

   ring_counter dut_a (
      .clk   (clk),
      .sw    (sw),
      .LED_1 (a1),
      .LED_2 (a2),
      .LED_3 (a3),
      .LED_4 (a4)
   );

   ring_counter #(
      .STEP_DIV  (3),
      .RESET_POS (2)
   ) dut_b (
      .clk   (clk),
      .sw    (sw),
      .LED_1 (b1),
      .LED_2 (b2),
      .LED_3 (b3),
      .LED_4 (b4)
   );

   // Monitor: samples on the falling edge or on an explicit async-check event.
   always @(negedge clk or chk_ev) begin
      exp_t e;
      logic [3:0] ra;
      logic [3:0] rb;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         ra = {a4, a3, a2, a1};
         rb = {b4, b3, b2, b1};
         checks = checks + 1;
         if (ra !== e.exp_a) begin
            errors = errors + 1;
            $display("FAIL ring_a step %0d: got %b expected %b", e.step, ra, e.exp_a);
         end
         checks = checks + 1;
         if (rb !== e.exp_b) begin
            errors = errors + 1;
            $display("FAIL ring_b step %0d: got %b expected %b", e.step, rb, e.exp_b);
         end
         checks = checks + 1;
         if ($countones(ra) != 1 || $countones(rb) != 1) begin
            errors = errors + 1;
            $display("FAIL onehot step %0d: got a=%b b=%b expected one bit each", e.step, ra, rb);
         end
      end
   end

   int step_no;

   task automatic push(input logic [3:0] ea, input logic [3:0] eb);
      exp_t e;
      e.exp_a = ea;
      e.exp_b = eb;
      e.step  = step_no;
      step_no = step_no + 1;
      exp_q.push_back(e);
   endtask

   task automatic edge_chk(input logic [3:0] ea, input logic [3:0] eb);
      push(ea, eb);
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      #1;
   endtask

   task automatic async_chk(input logic [3:0] ea, input logic [3:0] eb);
      push(ea, eb);
      #1 -> chk_ev;
      #1;
   endtask

   // Expected patterns as {LED_4,LED_3,LED_2,LED_1}, worked out by hand.
   logic [3:0] seq_a [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                             4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] seq_b [8] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000,
                             4'b1000, 4'b0001, 4'b0001, 4'b0001};

   initial begin
      checks  = 0;
      errors  = 0;
      step_no = 0;
      clk     = 1'b0;
      sw      = 1'b0;

      // Reset with clock idle: patterns must appear before any edge.
      #3 sw = 1'b1;
      async_chk(4'b0001, 4'b0100);

      // Edges while reset is held: both rings stay at reset pattern.
      edge_chk(4'b0001, 4'b0100);
      edge_chk(4'b0001, 4'b0100);

      #2 sw = 1'b0;
      #2;
      for (int i = 0; i < 8; i++) begin
         edge_chk(seq_a[i], seq_b[i]);
      end

      // Two more edges: a lights LED_3; b ticks on edge 9 to LED_2.
      edge_chk(4'b0010, 4'b0010);
      edge_chk(4'b0100, 4'b0010);

      // Mid-operation reset pulse between edges.
      sw = 1'b1;
      async_chk(4'b0001, 4'b0100);
      sw = 1'b0;
      #2;
      edge_chk(4'b0010, 4'b0100);
      edge_chk(4'b0100, 4'b0100);
      edge_chk(4'b1000, 4'b1000);
      edge_chk(4'b0001, 4'b1000);

      #20;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
